// File: rtl/zet_mem_defs_pkg.sv
// Shared memory-controller definitions: FSM state encodings and strobe default.
// Used by the SRAM and flash controllers alike.
package zet_mem_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP1 = 3'd1,
        ST_STRB1  = 3'd2,
        ST_SETUP2 = 3'd3,
        ST_STRB2  = 3'd4,
        ST_DONE   = 3'd5
    } mem_state_e;

    localparam int STRB_CYCLES_DEF = 2;

    function automatic logic is_access(input mem_state_e s);
        return (s == ST_SETUP1) || (s == ST_STRB1) ||
               (s == ST_SETUP2) || (s == ST_STRB2);
    endfunction

    function automatic logic is_strb(input mem_state_e s);
        return (s == ST_STRB1) || (s == ST_STRB2);
    endfunction

endpackage

// File: rtl/sram_strb_cnt.sv
// Strobe-length down-counter: load at SETUP, count down through STRB.
// last_o flags the final strobe cycle.
module sram_strb_cnt #(
    parameter int STRB_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    localparam logic [3:0] LOAD_VAL = 4'(STRB_CYCLES - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_zet_cntrlr.sv
// Asynchronous 16-bit SRAM controller: byte/word accesses, with odd-address
// word accesses split into two byte-lane accesses.
module sram_zet_cntrlr
    import zet_mem_defs_pkg::*;
#(
    parameter int STRB_CYCLES = STRB_CYCLES_DEF
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        byte_m,
    input  logic        enable,
    output logic [15:0] rd_data,
    output logic        ready,
    output logic [18:0] SR_A,
    inout  wire  [15:0] SR_D,
    output logic        SR_CE_N,
    output logic        SR_OE_N,
    output logic        SR_WE_N,
    output logic        SR_UB_N,
    output logic        SR_LB_N
);

    mem_state_e  state_q, state_d;
    logic [18:0] sra_q;
    logic        a0_q;
    logic [15:0] wd_q;
    logic        we_q;
    logic        bm_q;
    logic        ph_q;
    logic [15:0] rd_q;
    logic        oe_q;

    logic        cap;
    logic        cnt_load;
    logic        cnt_dec;
    logic        last;
    logic        split;
    logic        we_nx;
    logic        oe_d;
    logic        ub_en;
    logic        lb_en;
    logic        acc;
    logic [15:0] dout;
    logic [15:0] rd_first;

    assign split = ~bm_q & a0_q;

    sram_strb_cnt #(
        .STRB_CYCLES(STRB_CYCLES)
    ) u_strb_cnt (
        .clk_i (sys_clk),
        .rst_i (reset),
        .load_i(cnt_load),
        .dec_i (cnt_dec),
        .last_o(last)
    );

    always_comb begin
        state_d  = state_q;
        cap      = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    cap     = 1'b1;
                    state_d = ST_SETUP1;
                end
            end
            ST_SETUP1: begin
                cnt_load = 1'b1;
                state_d  = ST_STRB1;
            end
            ST_STRB1: begin
                if (last) begin
                    state_d = split ? ST_SETUP2 : ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETUP2: begin
                cnt_load = 1'b1;
                state_d  = ST_STRB2;
            end
            ST_STRB2: begin
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus stays driven one cycle past the last write strobe for hold time.
    assign we_nx = cap ? we : we_q;
    assign oe_d  = we_nx & (is_access(state_d) | is_access(state_q));

    always_comb begin
        rd_first = SR_D;
        if (split) begin
            rd_first = {rd_q[15:8], SR_D[15:8]};
        end else if (bm_q) begin
            rd_first = a0_q ? {8'h00, SR_D[15:8]} : {8'h00, SR_D[7:0]};
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sra_q   <= '0;
            a0_q    <= 1'b0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            bm_q    <= 1'b0;
            ph_q    <= 1'b0;
            rd_q    <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            if (cap) begin
                sra_q <= addr[19:1];
                a0_q  <= addr[0];
                wd_q  <= wr_data;
                we_q  <= we;
                bm_q  <= byte_m;
                ph_q  <= 1'b0;
            end
            if (state_q == ST_STRB1 && last) begin
                if (!we_q) begin
                    rd_q <= rd_first;
                end
                if (split) begin
                    sra_q <= sra_q + 19'd1;
                    ph_q  <= 1'b1;
                end
            end
            if (state_q == ST_STRB2 && last && !we_q) begin
                rd_q[15:8] <= SR_D[7:0];
            end
        end
    end

    always_comb begin
        ub_en = 1'b1;
        lb_en = 1'b1;
        dout  = wd_q;
        if (ph_q) begin
            ub_en = 1'b0;
            dout  = {8'h00, wd_q[15:8]};
        end else if (split || (bm_q && a0_q)) begin
            lb_en = 1'b0;
            dout  = {wd_q[7:0], 8'h00};
        end else if (bm_q) begin
            ub_en = 1'b0;
            dout  = {8'h00, wd_q[7:0]};
        end
    end

    assign acc     = is_access(state_q);
    assign SR_CE_N = ~acc;
    assign SR_OE_N = ~(is_strb(state_q) & ~we_q);
    assign SR_WE_N = ~(is_strb(state_q) & we_q);
    assign SR_UB_N = ~(acc & ub_en);
    assign SR_LB_N = ~(acc & lb_en);
    assign SR_A    = sra_q;
    assign SR_D    = oe_q ? dout : 16'hzzzz;
    assign rd_data = rd_q;
    assign ready   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_zet_cntrlr.sv
// Bench for sram_zet_cntrlr: table of directed accesses on a 2-strobe
// instance with an SRAM model, plus reset/enable corner cases and a 1-strobe instance.
module tb_sram_zet_cntrlr;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        byte_m;
    logic        en0;
    logic        en1;
    logic        s;

    wire  [15:0] rd0, rd1;
    wire         rdy0, rdy1;
    wire  [18:0] sra0, sra1;
    wire  [15:0] sd0, sd1;
    wire         ce0, oe0, we0n, ub0, lb0;
    wire         ce1, oe1, we1n, ub1, lb1;

    logic [15:0] mem0 [0:1023];
    logic        ld_en;
    logic [9:0]  ld_a;
    logic [15:0] ld_d;

    int checks = 0;
    int errors = 0;
    int ce1_cnt = 0;

    always #5 clk = ~clk;

    sram_zet_cntrlr #(.STRB_CYCLES(2)) dut0 (
        .sys_clk(clk), .reset(rst), .addr(addr), .wr_data(wr_data),
        .we(we), .byte_m(byte_m), .enable(en0), .rd_data(rd0),
        .ready(rdy0), .SR_A(sra0), .SR_D(sd0), .SR_CE_N(ce0),
        .SR_OE_N(oe0), .SR_WE_N(we0n), .SR_UB_N(ub0), .SR_LB_N(lb0)
    );

    sram_zet_cntrlr #(.STRB_CYCLES(1)) dut1 (
        .sys_clk(clk), .reset(rst), .addr(addr), .wr_data(wr_data),
        .we(we), .byte_m(byte_m), .enable(en1), .rd_data(rd1),
        .ready(rdy1), .SR_A(sra1), .SR_D(sd1), .SR_CE_N(ce1),
        .SR_OE_N(oe1), .SR_WE_N(we1n), .SR_UB_N(ub1), .SR_LB_N(lb1)
    );

    // SRAM models: a real array for dut0, an address pattern for dut1
    assign sd0 = (!ce0 && !oe0) ? mem0[sra0[9:0]] : 16'hzzzz;
    assign sd1 = (!ce1 && !oe1) ? (sra1[15:0] ^ 16'h5500) : 16'hzzzz;

    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_a] <= ld_d;
        end else if (!ce0 && !we0n) begin
            if (!ub0) mem0[sra0[9:0]][15:8] <= sd0[15:8];
            if (!lb0) mem0[sra0[9:0]][7:0]  <= sd0[7:0];
        end
    end

    always @(negedge clk) begin
        if (!ce1) ce1_cnt <= ce1_cnt + 1;
    end

    wire        s_ready = s ? rdy1 : rdy0;
    wire [15:0] s_rd    = s ? rd1  : rd0;
    wire [18:0] s_sra   = s ? sra1 : sra0;
    wire        s_ce    = s ? ce1  : ce0;
    wire        s_oe    = s ? oe1  : oe0;
    wire        s_we    = s ? we1n : we0n;
    wire        s_ub    = s ? ub1  : ub0;
    wire        s_lb    = s ? lb1  : lb0;

    typedef struct {
        logic [19:0] a;
        logic [15:0] wd;
        logic        w;
        logic        b;
        logic [18:0] sra;
        logic [18:0] sra2;
        logic        ub;
        logic        lb;
        logic [15:0] rd;
        int          lat;
        int          nstrb;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_load(input logic [9:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with enable low and dut idle.
    task automatic do_access(
        input  logic        sel,
        input  logic [19:0] a,
        input  logic [15:0] wd,
        input  logic        w,
        input  logic        b,
        input  int          nhold,
        output int          lat,
        output logic [18:0] sra_f,
        output logic [18:0] sra_l,
        output logic        ub_f,
        output logic        lb_f,
        output int          nstrb,
        output logic [15:0] rd_r
    );
        bit first;
        s       = sel;
        addr    = a;
        wr_data = wd;
        we      = w;
        byte_m  = b;
        if (sel) en1 = 1'b1;
        else     en0 = 1'b1;
        lat = 0; nstrb = 0; first = 1'b1;
        sra_f = '0; sra_l = '0; ub_f = 1'b1; lb_f = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                addr    = ~a;
                wr_data = ~wd;
                we      = ~w;
                byte_m  = ~b;
            end
            if (!s_ce) begin
                if (first) begin
                    sra_f = s_sra; ub_f = s_ub; lb_f = s_lb;
                    first = 1'b0;
                end
                sra_l = s_sra;
                if (!s_oe || !s_we) nstrb++;
            end
            if (s_ready) break;
        end
        if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
        rd_r = s_rd;
        for (int i = 0; i < nhold; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(s_ready), 32'd1);
            chk("hold_rd", 32'(s_rd), 32'(rd_r));
        end
        if (sel) en1 = 1'b0;
        else     en0 = 1'b0;
        @(negedge clk);
        chk("ready_drop", 32'(s_ready), 32'd0);
    endtask

    int          lat, nstrb, rcnt, c0;
    logic [18:0] sra_f, sra_l;
    logic        ub_f, lb_f;
    logic [15:0] rd_r;
    logic [19:0] a1 [4];
    logic [15:0] e1 [4];

    initial begin
        vt[0] = '{20'h01234, 16'h0000, 1'b0, 1'b0, 19'h0091A, 19'h0091A, 1'b0, 1'b0, 16'hBEEF, 4, 2};
        vt[1] = '{20'h00011, 16'h5AA5, 1'b1, 1'b1, 19'h00008, 19'h00008, 1'b0, 1'b1, 16'hBEEF, 4, 2};
        vt[2] = '{20'hFFFFF, 16'h0000, 1'b0, 1'b0, 19'h7FFFF, 19'h00000, 1'b0, 1'b1, 16'h3412, 7, 4};
        vt[3] = '{20'h00011, 16'h0000, 1'b0, 1'b1, 19'h00008, 19'h00008, 1'b0, 1'b1, 16'h00A5, 4, 2};
        vt[4] = '{20'h01234, 16'h0000, 1'b0, 1'b1, 19'h0091A, 19'h0091A, 1'b1, 1'b0, 16'h00EF, 4, 2};
        vt[5] = '{20'h00200, 16'hCAFE, 1'b1, 1'b0, 19'h00100, 19'h00100, 1'b0, 1'b0, 16'h00EF, 4, 2};
        vt[6] = '{20'h00401, 16'h1357, 1'b1, 1'b0, 19'h00200, 19'h00201, 1'b0, 1'b1, 16'h00EF, 7, 4};
        vt[7] = '{20'h00401, 16'h0000, 1'b0, 1'b0, 19'h00200, 19'h00201, 1'b0, 1'b1, 16'h1357, 7, 4};
        a1[0] = 20'h00010; e1[0] = 16'h5508;
        a1[1] = 20'h00020; e1[1] = 16'h5510;
        a1[2] = 20'h0ABC4; e1[2] = 16'h00E2;
        a1[3] = 20'h00100; e1[3] = 16'h5580;

        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; s = 1'b0; ld_en = 1'b0;
        ld_a = '0; ld_d = '0;
        addr = '0; wr_data = '0; we = 1'b0; byte_m = 1'b0;
        mem_load(10'h11A, 16'hBEEF);
        mem_load(10'h3FF, 16'h12CD);
        mem_load(10'h000, 16'hAB34);
        mem_load(10'h080, 16'h7777);
        mem_load(10'h008, 16'h0000);
        mem_load(10'h100, 16'h0000);
        mem_load(10'h200, 16'h0000);
        mem_load(10'h201, 16'h0000);

        @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_rd", 32'(rd0), 32'h0);
        chk("rst_sra", 32'(sra0), 32'h0);
        chk("rst_ctl", 32'({ce0, oe0, we0n, ub0, lb0}), 32'h1F);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_access(1'b0, vt[i].a, vt[i].wd, vt[i].w, vt[i].b, 2,
                      lat, sra_f, sra_l, ub_f, lb_f, nstrb, rd_r);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_sra", i), 32'(sra_f), 32'(vt[i].sra));
            chk($sformatf("v%0d_sra2", i), 32'(sra_l), 32'(vt[i].sra2));
            chk($sformatf("v%0d_ub", i), 32'(ub_f), 32'(vt[i].ub));
            chk($sformatf("v%0d_lb", i), 32'(lb_f), 32'(vt[i].lb));
            chk($sformatf("v%0d_rd", i), 32'(rd_r), 32'(vt[i].rd));
            chk($sformatf("v%0d_strb", i), 32'(nstrb), 32'(vt[i].nstrb));
        end
        chk("mem_008", 32'(mem0[10'h008]), 32'h0000A500);
        chk("mem_100", 32'(mem0[10'h100]), 32'h0000CAFE);
        chk("mem_200", 32'(mem0[10'h200]), 32'h00005700);
        chk("mem_201", 32'(mem0[10'h201]), 32'h00000013);

        // enable withdrawn during STRB1 of a read
        s = 1'b0; addr = 20'h01234; we = 1'b0; byte_m = 1'b0; en0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en0 = 1'b0;
        rcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rdy0) rcnt++;
        end
        chk("drop_ready_cycles", 32'(rcnt), 32'd1);
        chk("drop_idle_ce", 32'(ce0), 32'd1);
        chk("drop_rd", 32'(rd0), 32'hBEEF);

        // reset in STRB2 of a split write
        addr = 20'h00601; wr_data = 16'h2468; we = 1'b1; byte_m = 1'b0;
        en0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("strb2_we", 32'(we0n), 32'd0);
        chk("strb2_sra", 32'(sra0), 32'h301);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(we0n), 32'd1);
        chk("mid_rst_ready", 32'(rdy0), 32'd0);
        chk("mid_rst_rd", 32'(rd0), 32'h0);
        chk("mid_rst_ctl", 32'({ce0, oe0, ub0, lb0, sra0}), 32'({4'hF, 19'h0}));
        en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_access(1'b0, 20'h00100, 16'h0, 1'b0, 1'b0, 0,
                  lat, sra_f, sra_l, ub_f, lb_f, nstrb, rd_r);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_sra", 32'(sra_f), 32'h080);
        chk("post_rst_rd", 32'(rd_r), 32'h7777);

        // single-strobe instance, back-to-back with enable toggled
        c0 = ce1_cnt;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b1, a1[i], 16'h0, 1'b0, 1'b0, 0,
                      lat, sra_f, sra_l, ub_f, lb_f, nstrb, rd_r);
            chk($sformatf("s1_%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("s1_%0d_rd", i), 32'(rd_r), 32'(e1[i]));
            chk($sformatf("s1_%0d_strb", i), 32'(nstrb), 32'd1);
        end
        chk("s1_ce_cycles", 32'(ce1_cnt - c0), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_zet_cntrlr.md
SRAM_ZET_CNTRLR -- requirements
Module: sram_zet_cntrlr

Interface
REQ-001 The block SHALL have one parameter: STRB_CYCLES, default 2, number of cycles OE_N/WE_N are held low per SRAM access (legal values 1..15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be:
- sys_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- addr  in  20  CPU byte address.
- wr_data  in  16  write data; byte writes use [7:0].
- we  in  1  1 = write, 0 = read.
- byte_m  in  1  1 = byte access, 0 = word access.
- enable  in  1  request level from the memory router (RAM area).
- rd_data  out  16  read data.
- ready  out  1  access complete.
- SR_A  out  19  SRAM word address.
- SR_D  inout  16  SRAM data bus.
- SR_CE_N, SR_OE_N, SR_WE_N, SR_UB_N, SR_LB_N  out  1 each  SRAM controls, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP1, STRB1, SETUP2, STRB2 and DONE.
REQ-005 In IDLE with enable=1, the block SHALL capture addr, wr_data, we and byte_m, then enter SETUP1; input changes after capture SHALL be ignored until IDLE.
REQ-006 Each access SHALL be one SETUP cycle followed by STRB_CYCLES STRB cycles.
- SETUP: CE_N=0, address and lanes valid, OE_N=WE_N=1.
- STRB: OE_N=0 for a read, WE_N=0 for a write.
REQ-007 The block SHALL register read data from SR_D on the last STRB cycle.
REQ-008 The block SHALL drive SR_D during SETUP and STRB of a write and for the following cycle (hold), and SHALL tristate SR_D otherwise.
REQ-009 Lane mapping SHALL be:
- byte, addr[0]=0: LB only; rd_data={8'h00,SR_D[7:0]}; write drives wr_data[7:0] on SR_D[7:0].
- byte, addr[0]=1: UB only; rd_data={8'h00,SR_D[15:8]}; write drives wr_data[7:0] on SR_D[15:8].
- word, addr[0]=0: UB and LB, one access; rd_data=SR_D.
REQ-010 A word access with addr[0]=1 SHALL be split into two accesses.
- First access: SR_A=addr[19:1], UB lane, data byte [7:0].
- Second access (SETUP2/STRB2): SR_A=addr[19:1]+1 modulo 2^19, LB lane, data byte [15:8].
REQ-011 All other accesses SHALL go from STRB1 directly to DONE.
REQ-012 In DONE the block SHALL assert ready=1, hold rd_data stable, keep SRAM controls inactive, and remain in DONE while enable=1.
REQ-013 The block SHALL return from DONE to IDLE in the cycle after enable is sampled 0, and ready SHALL drop in that same transition.
REQ-014 If enable falls during an access, the block SHALL complete the access, assert ready for exactly one cycle, then return to IDLE.
REQ-015 ready SHALL be 0 in every state except DONE.
REQ-016 Total latency from enable sampled in IDLE to ready=1 SHALL be (1+STRB_CYCLES)+1 cycles for one access and 2*(1+STRB_CYCLES)+1 cycles for a split access.
REQ-017 A write SHALL leave rd_data unchanged.

Reset
REQ-018 Asserting reset at any time, including mid-access, SHALL immediately force:
- state IDLE, ready=0, rd_data=16'h0000, SR_A=0;
- SR_CE_N, SR_OE_N, SR_WE_N, SR_UB_N and SR_LB_N all 1;
- SR_D tristated.
REQ-019 After reset is released, the first request SHALL be accepted on the first rising edge with enable=1.

Structure
REQ-020 State encodings and the STRB_CYCLES default SHALL live in a shared include header, zet_mem_defs, reused by the flash and SRAM controllers.
REQ-021 The strobe-length down-counter SHALL be a sub-module, sram_strb_cnt: load, decrement and a last flag.
REQ-022 SR_D tristate control SHALL be a single output-enable register in the top module.

Verification
REQ-023 With STRB_CYCLES=2, a bench SHALL cover these scenarios:
- Word read, addr=20'h01234, SRAM word 0x091A holds 16'hBEEF -> SR_A=19'h0091A, UB_N=LB_N=0, rd_data=16'hBEEF, ready at cycle 4, held until enable=0.
- Byte write, addr=20'h00011, wr_data=16'h5AA5 -> SR_A=19'h00008, UB_N=0, LB_N=1, SR_D[15:8]=8'hA5, WE_N low for exactly 2 cycles; rd_data unchanged.
- Word read at odd address 20'hFFFFF, words 0x7FFFF=16'h12xx and 0x00000=16'hxx34 -> second SR_A=19'h00000, rd_data=16'h3412, ready at cycle 7.
- enable dropped in STRB1 of a read -> access completes, ready high exactly 1 cycle, next state IDLE.
- reset asserted in STRB2 of a split write -> same cycle WE_N=1, SR_D high-Z, ready=0, rd_data=0; a following read of 20'h00100 completes normally.
- STRB_CYCLES=1, back-to-back requests with enable toggled -> each access takes 3 cycles to ready, with no missed or duplicated access.
